// File: rtl/sentry_ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sentry_ahb_pkg
//  Description : Shared AHB-Lite encodings and the arbiter state type for the
//                sentry sys_ctrl requestor path.
//                Contents:
//                  HTRANS_* / HBURST_* / HSIZE_* / HPROT_* encodings
//                  arb_state_t  : arbiter FSM states
//                  align_mask() : low address bits that must be zero for a size
//  Revision    : 1.0 - initial release
// ============================================================================
package sentry_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2,
    ARB_RSP  = 2'd3
  } arb_state_t;

  // Sizes above a doubleword never reach this check legally (they are
  // rejected as oversize first), so they share the widest mask.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    case (size)
      HSIZE_BYTE:  align_mask = 3'b000;
      HSIZE_HALF:  align_mask = 3'b001;
      HSIZE_WORD:  align_mask = 3'b011;
      HSIZE_DWORD: align_mask = 3'b111;
      default:     align_mask = 3'b111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sentry_sys_ctrl_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sentry_sys_ctrl_arbiter_if
//  Description : AHB-Lite manager bundle for the sentry sys_ctrl port.
//                master modport : driven by the arbiter (addr/ctrl/wdata out,
//                                 hrdata/hready/hresp in)
//                slave modport  : the subordinate view of the same signals
//  Revision    : 1.0 - initial release
// ============================================================================
interface sentry_sys_ctrl_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] sys_ctrl_haddr;
  logic [2:0]        sys_ctrl_hburst;
  logic              sys_ctrl_hmastlock;
  logic [3:0]        sys_ctrl_hprot;
  logic              sys_ctrl_hnonsec;
  logic [2:0]        sys_ctrl_hsize;
  logic [1:0]        sys_ctrl_htrans;
  logic [DATA_W-1:0] sys_ctrl_hwdata;
  logic              sys_ctrl_hwrite;
  logic [DATA_W-1:0] sys_ctrl_hrdata;
  logic              sys_ctrl_hready;
  logic              sys_ctrl_hresp;

  modport master (
    output sys_ctrl_haddr, sys_ctrl_hburst, sys_ctrl_hmastlock, sys_ctrl_hprot,
           sys_ctrl_hnonsec, sys_ctrl_hsize, sys_ctrl_htrans, sys_ctrl_hwdata,
           sys_ctrl_hwrite,
    input  sys_ctrl_hrdata, sys_ctrl_hready, sys_ctrl_hresp
  );

  modport slave (
    input  sys_ctrl_haddr, sys_ctrl_hburst, sys_ctrl_hmastlock, sys_ctrl_hprot,
           sys_ctrl_hnonsec, sys_ctrl_hsize, sys_ctrl_htrans, sys_ctrl_hwdata,
           sys_ctrl_hwrite,
    output sys_ctrl_hrdata, sys_ctrl_hready, sys_ctrl_hresp
  );
endinterface
`default_nettype wire

// File: rtl/sentry_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sentry_rr_arbiter
//  Description : Two-way round-robin grant. On a tie the client that was not
//                served last wins.
//                req[1:0] in  : requests
//                last     in  : index of the client served last
//                en       in  : grant enable (0 forces gnt to zero)
//                gnt[1:0] out : one-hot grant
//  Revision    : 1.0 - initial release
// ============================================================================
module sentry_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sentry_sys_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sentry_sys_ctrl_arbiter
//  Description : Shares the sentry AHB-Lite sys_ctrl requestor port between
//                client 0 (secure-boot engine) and client 1 (mailbox/debug).
//                One non-pipelined SINGLE transfer at a time.
//                clk_in, rst_n           : clock, async active-low reset
//                req_valid/ready/write   : per-client request handshake
//                req_addr/wdata/size     : packed per-client payload
//                rsp_valid/rdata/err     : one-cycle completion per client
//                busy                    : FSM not idle
//                sys_ctrl                : AHB-Lite manager interface
//  Revision    : 1.0 - initial release
// ============================================================================
module sentry_sys_ctrl_arbiter
  import sentry_ahb_pkg::*;
#(
  parameter int   ADDR_W = 32,
  parameter int   DATA_W = 32,
  parameter logic NONSEC = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [5:0]            req_size,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  sentry_sys_ctrl_arbiter_if.master sys_ctrl
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  arb_state_t        state_q, state_d;
  logic              last_q, served_q;
  logic              client_q, wr_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [2:0]        size_q;

  logic [1:0]        gnt;
  logic              gnt_idx, rr_last, bad_req, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_size;

  // Before the first completion nobody has been served; presenting client 1
  // as "last" makes client 0 win the very first tie.
  assign rr_last = served_q ? last_q : 1'b1;

  sentry_rr_arbiter u_rr (
    .req  (req_valid),
    .last (rr_last),
    .en   (state_q == ARB_IDLE),
    .gnt  (gnt)
  );

  assign gnt_idx   = gnt[1];
  assign sel_write = req_write[gnt_idx];
  assign sel_addr  = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign sel_size  = gnt_idx ? req_size[5:3] : req_size[2:0];
  assign bad_req   = (sel_size > MAX_SIZE) || (|(sel_addr[2:0] & align_mask(sel_size)));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      last_q   <= 1'b0;
      served_q <= 1'b0;
      client_q <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && |gnt) begin
        client_q <= gnt_idx;
        wr_q     <= sel_write;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        size_q   <= sel_size;
        rdata_q  <= '0;
        err_q    <= bad_req;
      end
      if (state_q == ARB_DATA && sys_ctrl.sys_ctrl_hready) begin
        err_q   <= sys_ctrl.sys_ctrl_hresp;
        rdata_q <= (!wr_q && !sys_ctrl.sys_ctrl_hresp) ? sys_ctrl.sys_ctrl_hrdata : '0;
      end
      if (state_q == ARB_RSP) begin
        last_q   <= client_q;
        served_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (|gnt) begin
          req_ready = gnt;
          // Illegal size/alignment skips the bus and reports an error directly.
          state_d   = bad_req ? ARB_RSP : ARB_ADDR;
        end
      end
      ARB_ADDR: if (sys_ctrl.sys_ctrl_hready) state_d = ARB_DATA;
      ARB_DATA: if (sys_ctrl.sys_ctrl_hready) state_d = ARB_RSP;
      ARB_RSP:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign busy      = (state_q != ARB_IDLE);
  assign rsp_valid = (state_q == ARB_RSP) ? (client_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = (state_q == ARB_RSP) ? rdata_q : '0;
  assign rsp_err   = (state_q == ARB_RSP) ? err_q : 1'b0;

  assign sys_ctrl.sys_ctrl_htrans    = (state_q == ARB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign sys_ctrl.sys_ctrl_haddr     = (state_q == ARB_ADDR) ? addr_q : '0;
  assign sys_ctrl.sys_ctrl_hwrite    = (state_q == ARB_ADDR) ? wr_q : 1'b0;
  assign sys_ctrl.sys_ctrl_hsize     = (state_q == ARB_ADDR) ? size_q : 3'd0;
  assign sys_ctrl.sys_ctrl_hwdata    = (state_q == ARB_DATA && wr_q) ? wdata_q : '0;
  assign sys_ctrl.sys_ctrl_hburst    = HBURST_SINGLE;
  assign sys_ctrl.sys_ctrl_hmastlock = 1'b0;
  assign sys_ctrl.sys_ctrl_hprot     = HPROT_DATA;
  assign sys_ctrl.sys_ctrl_hnonsec   = NONSEC;

endmodule
`default_nettype wire

// File: tb/tb_sentry_sys_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sentry_sys_ctrl_arbiter
//  Description : Self-checking bench for sentry_sys_ctrl_arbiter. A
//                transaction-level model (pending request table, round-robin
//                bookkeeping, arithmetic alignment rule) predicts grants,
//                bus phases and responses for directed and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sentry_sys_ctrl_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [5:0]  req_size;
  logic [31:0] rsp_rdata;
  logic        rsp_err, busy;

  int checks = 0;
  int errors = 0;

  bit          pend  [2];
  bit          p_wr  [2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdat[2];
  logic [2:0]  p_size[2];
  bit          m_served;
  int          m_last;

  sentry_sys_ctrl_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sentry_sys_ctrl_arbiter #(.ADDR_W(32), .DATA_W(32), .NONSEC(1'b0)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .sys_ctrl  (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [2:0] s, input logic [31:0] a);
    if (s > 3'd2) return 1'b1;
    return (a % (32'd1 << s)) != 0;
  endfunction

  task automatic post(input int c, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] s);
    pend[c] = 1'b1; p_wr[c] = w; p_addr[c] = a; p_wdat[c] = d; p_size[c] = s;
  endtask

  task automatic drive_reqs();
    for (int c = 0; c < 2; c++) begin
      req_valid[c]          = pend[c];
      req_write[c]          = p_wr[c];
      req_addr[c*32 +: 32]  = p_addr[c];
      req_wdata[c*32 +: 32] = p_wdat[c];
      req_size[c*3 +: 3]    = p_size[c];
    end
  endtask

  // Entered at posedge+1 of a cycle in which the DUT is expected to be idle.
  // aw/dw: hready-low cycles in address/data phase; serr: two-cycle error.
  task automatic run_xfer(input int aw, input int dw, input bit serr, input logic [31:0] rd);
    int          g, n;
    bit          bad, wr, exp_err;
    logic [31:0] a, d;
    logic [2:0]  s;
    if (pend[0] && pend[1]) g = m_served ? 1 - m_last : 0;
    else                    g = pend[1] ? 1 : 0;
    wr = p_wr[g]; a = p_addr[g]; d = p_wdat[g]; s = p_size[g];
    bad = is_bad(s, a);
    drive_reqs();
    bus.sys_ctrl_hready = 1'b1; bus.sys_ctrl_hresp = 1'b0; bus.sys_ctrl_hrdata = $urandom;
    #1;
    chk_eq("grant_ready", req_ready, (g == 0) ? 2'b01 : 2'b10);
    chk_eq("grant_htrans", bus.sys_ctrl_htrans, 2'b00);
    chk_eq("grant_busy", busy, 1'b0);
    pend[g] = 1'b0;
    if (!bad) begin
      for (int i = 0; i <= aw; i++) begin
        @(posedge clk_in); #1;
        drive_reqs();
        bus.sys_ctrl_hready = (i == aw); bus.sys_ctrl_hresp = 1'b0; bus.sys_ctrl_hrdata = $urandom;
        #1;
        chk_eq("addr_htrans", bus.sys_ctrl_htrans, 2'b10);
        chk_eq("addr_haddr", bus.sys_ctrl_haddr, a);
        chk_eq("addr_hwrite", bus.sys_ctrl_hwrite, wr);
        chk_eq("addr_hsize", bus.sys_ctrl_hsize, s);
        chk_eq("addr_ctrl", {bus.sys_ctrl_hburst, bus.sys_ctrl_hmastlock, bus.sys_ctrl_hprot}, 8'h03);
        chk_eq("addr_hs", {req_ready, rsp_valid, busy}, 5'b00001);
      end
      n = dw + (serr ? 1 : 0);
      for (int i = 0; i <= n; i++) begin
        @(posedge clk_in); #1;
        drive_reqs();
        bus.sys_ctrl_hready = (i == n);
        bus.sys_ctrl_hresp  = serr && (i >= dw);
        bus.sys_ctrl_hrdata = (i == n) ? rd : $urandom;
        #1;
        chk_eq("data_htrans", bus.sys_ctrl_htrans, 2'b00);
        chk_eq("data_hwdata", bus.sys_ctrl_hwdata, wr ? d : 32'h0);
        chk_eq("data_hs", {req_ready, rsp_valid, busy}, 5'b00001);
      end
    end
    @(posedge clk_in); #1;
    drive_reqs();
    bus.sys_ctrl_hready = 1'b1; bus.sys_ctrl_hresp = 1'b0; bus.sys_ctrl_hrdata = $urandom;
    #1;
    exp_err = bad || serr;
    chk_eq("rsp_valid", rsp_valid, (g == 0) ? 2'b01 : 2'b10);
    chk_eq("rsp_err", rsp_err, exp_err);
    chk_eq("rsp_rdata", rsp_rdata, (!wr && !exp_err) ? rd : 32'h0);
    chk_eq("rsp_bus", {bus.sys_ctrl_htrans, req_ready, busy}, 5'b00001);
    m_last = g; m_served = 1'b1;
    @(posedge clk_in); #1;
  endtask

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_size = '0;
    bus.sys_ctrl_hready = 1'b1; bus.sys_ctrl_hresp = 1'b0; bus.sys_ctrl_hrdata = '0;
    for (int c = 0; c < 2; c++) post(c, 1'b0, 32'h0, 32'h0, 3'd0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    m_served = 1'b0; m_last = 0;

    repeat (3) @(posedge clk_in);
    #1;
    chk_eq("rst_hs", {req_ready, rsp_valid, rsp_err, busy}, 6'b0);
    chk_eq("rst_rdata", rsp_rdata, 32'h0);
    chk_eq("rst_bus", {bus.sys_ctrl_htrans, bus.sys_ctrl_haddr, bus.sys_ctrl_hwdata,
                       bus.sys_ctrl_hwrite, bus.sys_ctrl_hsize}, 70'h0);
    chk_eq("rst_const", {bus.sys_ctrl_hburst, bus.sys_ctrl_hmastlock, bus.sys_ctrl_hprot,
                         bus.sys_ctrl_hnonsec}, 9'b000_0_0011_0);
    rst_n = 1'b1;
    @(posedge clk_in); #1;

    // Single aligned word read by client 0.
    post(0, 1'b0, 32'h1000, 32'h0, 3'd2);
    run_xfer(0, 0, 1'b0, 32'hDEADBEEF);

    // Simultaneous writes, then both held continuously: grants alternate.
    post(0, 1'b1, 32'h10, 32'h10, 3'd2);
    post(1, 1'b1, 32'h20, 32'h20, 3'd2);
    run_xfer(0, 0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) post(0, 1'b1, 32'h100 + 32'(k * 4), $urandom, 3'd2);
      if (!pend[1]) post(1, 1'b0, 32'h200 + 32'(k * 4), 32'h0, 3'd2);
      run_xfer(0, 0, 1'b0, $urandom);
    end
    while (pend[0] || pend[1]) run_xfer(0, 0, 1'b0, $urandom);

    // Write with three data-phase wait states.
    post(0, 1'b1, 32'h2000, 32'hA5A5A5A5, 3'd2);
    run_xfer(0, 3, 1'b0, 32'h0);

    // Two-cycle slave error on a read, then a normal read.
    post(1, 1'b0, 32'h3000, 32'h0, 3'd2);
    run_xfer(0, 0, 1'b1, 32'h12345678);
    post(1, 1'b0, 32'h3004, 32'h0, 3'd2);
    run_xfer(1, 1, 1'b0, 32'hCAFEF00D);

    // Misaligned word: no bus transfer, error response.
    post(1, 1'b0, 32'h1002, 32'h0, 3'd2);
    run_xfer(0, 0, 1'b0, 32'h0);

    // Reset asserted during the data phase.
    post(0, 1'b0, 32'h4000, 32'h0, 3'd2);
    drive_reqs(); bus.sys_ctrl_hready = 1'b1; #1;
    chk_eq("mrst_grant", req_ready, 2'b01);
    pend[0] = 1'b0;
    @(posedge clk_in); #1; drive_reqs(); bus.sys_ctrl_hready = 1'b1; #1;
    chk_eq("mrst_addr", bus.sys_ctrl_htrans, 2'b10);
    @(posedge clk_in); #1; drive_reqs(); bus.sys_ctrl_hready = 1'b0; #1;
    chk_eq("mrst_data", {bus.sys_ctrl_htrans, busy}, 3'b001);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("mrst_clear", {bus.sys_ctrl_htrans, busy, rsp_valid, rsp_err}, 6'b0);
    repeat (2) begin
      @(posedge clk_in); #1; bus.sys_ctrl_hready = 1'b1; #1;
      chk_eq("mrst_norsp", {rsp_valid, busy}, 3'b0);
    end
    m_served = 1'b0;
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    post(0, 1'b0, 32'h5000, 32'h0, 3'd2);
    post(1, 1'b1, 32'h5004, 32'h77, 3'd2);
    run_xfer(0, 0, 1'b0, 32'h0BADCAFE);

    // Random traffic.
    for (int it = 0; it < 150; it++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
          logic [31:0] a;
          a = $urandom;
          if ($urandom_range(0, 3) != 0) a = a & ~32'h7;
          post(c, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 3)));
        end
      end
      if (!pend[0] && !pend[1])
        post(int'($urandom_range(0, 1)), 1'b0, $urandom & ~32'h3, 32'h0, 3'd2);
      run_xfer(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 4) == 0), $urandom);
    end
    while (pend[0] || pend[1]) run_xfer(0, 0, 1'b0, $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
